timing_loop_gear_ctrl: RTL and testbench

// Sequences the symbol-timing PI loop filter through acquisition and tracking.

---
 rtl/timing_loop_gear_ctrl.sv | 242 ++++++++++++++++++++++++
 tb/tb_timing_loop_gear_ctrl.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/timing_loop_gear_ctrl.sv
// Symbol-timing loop gear controller: windowed |e| lock detector that sequences the
// PI loop filter through IDLE/ACQ/SETTLE/TRACK. Define LOCK_LOSS_REACQ_EN to reacquire on lock loss.
module timing_loop_gear_ctrl #(
    parameter int WERR      = 18,
    parameter int KP_ACQ    = 5,
    parameter int KI_ACQ    = 9,
    parameter int KP_TRK    = 7,
    parameter int KI_TRK    = 12,
    parameter int ACQ_SYMS  = 256,
    parameter int LOCK_WIN  = 64,
    parameter int LOCK_THR  = 512,
    parameter int LOCK_GOOD = 4,
    parameter int LOCK_BAD  = 2
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start_i,
    input  logic [WERR-1:0] e_in_i,
    input  logic            e_valid_i,
    output logic [4:0]      kp_shift_o,
    output logic [4:0]      ki_shift_o,
    output logic            lf_clr_o,
    output logic            lf_hold_o,
    output logic [1:0]      state_o,
    output logic            locked_o,
    output logic [WERR-1:0] win_avg_o
);
    localparam int LOG_WIN = $clog2(LOCK_WIN);
    localparam int ACC_W   = WERR + LOG_WIN;
    localparam int SYM_W   = $clog2(ACQ_SYMS + 1);
    localparam int GOOD_W  = $clog2(LOCK_GOOD + 1);
    localparam int BAD_W   = $clog2(LOCK_BAD + 1);

    localparam logic [SYM_W-1:0]   ACQ_SYMS_C  = SYM_W'(ACQ_SYMS);
    localparam logic [GOOD_W-1:0]  LOCK_GOOD_C = GOOD_W'(LOCK_GOOD);
    localparam logic [BAD_W-1:0]   LOCK_BAD_C  = BAD_W'(LOCK_BAD);
    localparam logic [WERR-1:0]    GOOD_THR_C  = WERR'(LOCK_THR);
    localparam logic [WERR-1:0]    BAD_THR_C   = WERR'(2 * LOCK_THR);
    localparam logic [LOG_WIN-1:0] WIN_LAST_C  = LOG_WIN'(LOCK_WIN - 1);
    localparam logic [4:0] KP_ACQ_C = 5'(KP_ACQ);
    localparam logic [4:0] KI_ACQ_C = 5'(KI_ACQ);
    localparam logic [4:0] KP_TRK_C = 5'(KP_TRK);
    localparam logic [4:0] KI_TRK_C = 5'(KI_TRK);

    typedef enum logic [1:0] {IDLE = 2'd0, ACQ = 2'd1, SETTLE = 2'd2, TRACK = 2'd3} state_t;

    // Magnitude with the most negative code clamped so it still fits in WERR bits.
    function automatic logic [WERR-1:0] abs_sat(input logic [WERR-1:0] e);
        logic [WERR-1:0] mag;
        if (e == {1'b1, {(WERR-1){1'b0}}}) begin
            mag = {1'b0, {(WERR-1){1'b1}}};
        end else if (e[WERR-1]) begin
            mag = ~e + {{(WERR-1){1'b0}}, 1'b1};
        end else begin
            mag = e;
        end
        return mag;
    endfunction

    state_t            state_r, state_n;
    logic [SYM_W-1:0]  sym_cnt_r, sym_cnt_n;
    logic [GOOD_W-1:0] good_cnt_r, good_cnt_n;
    logic [BAD_W-1:0]  bad_cnt_r, bad_cnt_n;
    logic              locked_r, locked_n;
    logic              lf_clr_r, lf_clr_n;
    logic              lf_hold_r, lf_hold_n;
    logic [4:0]        kp_r, kp_n, ki_r, ki_n;
    logic [ACC_W-1:0]  acc_r;
    logic [LOG_WIN-1:0] win_cnt_r;
    logic [WERR-1:0]   win_avg_r;
    logic              win_done_r;
    logic              win_clr_s, sample_s, good_win_s, bad_win_s;
    logic [ACC_W-1:0]  sum_s;

    // A start in the same cycle drops the sample; IDLE never accumulates.
    assign sample_s   = e_valid_i && !start_i && (state_r != IDLE);
    assign sum_s      = acc_r + {{LOG_WIN{1'b0}}, abs_sat(e_in_i)};
    assign good_win_s = (win_avg_r < GOOD_THR_C);
    assign bad_win_s  = (win_avg_r >= BAD_THR_C);

    // Window accumulator: mean |e| published one cycle after the last strobe.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_r      <= {ACC_W{1'b0}};
            win_cnt_r  <= {LOG_WIN{1'b0}};
            win_avg_r  <= {WERR{1'b0}};
            win_done_r <= 1'b0;
        end else begin
            win_done_r <= 1'b0;
            if (win_clr_s) begin
                acc_r     <= {ACC_W{1'b0}};
                win_cnt_r <= {LOG_WIN{1'b0}};
            end else if (sample_s) begin
                if (win_cnt_r == WIN_LAST_C) begin
                    win_avg_r  <= sum_s[ACC_W-1:LOG_WIN];
                    acc_r      <= {ACC_W{1'b0}};
                    win_cnt_r  <= {LOG_WIN{1'b0}};
                    win_done_r <= 1'b1;
                end else begin
                    acc_r     <= sum_s;
                    win_cnt_r <= win_cnt_r + LOG_WIN'(1);
                end
            end else begin
                acc_r <= acc_r;
            end
        end
    end

    // Next-state, counters and registered-output values.
    always_comb begin
        state_n    = state_r;
        sym_cnt_n  = sym_cnt_r;
        good_cnt_n = good_cnt_r;
        bad_cnt_n  = bad_cnt_r;
        locked_n   = locked_r;
        lf_clr_n   = 1'b0;
        win_clr_s  = 1'b0;
        if (start_i) begin
            state_n    = ACQ;
            sym_cnt_n  = {SYM_W{1'b0}};
            good_cnt_n = {GOOD_W{1'b0}};
            bad_cnt_n  = {BAD_W{1'b0}};
            locked_n   = 1'b0;
            lf_clr_n   = 1'b1;
            win_clr_s  = 1'b1;
        end else begin
            case (state_r)
                IDLE: begin
                    state_n = IDLE;
                end
                ACQ: begin
                    if (sample_s && (sym_cnt_r < ACQ_SYMS_C)) begin
                        sym_cnt_n = sym_cnt_r + SYM_W'(1);
                    end else begin
                        sym_cnt_n = sym_cnt_r;
                    end
                    // good_cnt counts earlier good windows; the deciding window must be good too.
                    if (win_done_r && good_win_s) begin
                        if ((sym_cnt_r >= ACQ_SYMS_C) && (good_cnt_r == LOCK_GOOD_C)) begin
                            state_n   = SETTLE;
                            win_clr_s = 1'b1;
                        end else if (good_cnt_r < LOCK_GOOD_C) begin
                            good_cnt_n = good_cnt_r + GOOD_W'(1);
                        end else begin
                            good_cnt_n = good_cnt_r;
                        end
                    end else if (win_done_r) begin
                        good_cnt_n = {GOOD_W{1'b0}};
                    end else begin
                        good_cnt_n = good_cnt_r;
                    end
                end
                SETTLE: begin
                    if (win_done_r && good_win_s) begin
                        state_n   = TRACK;
                        locked_n  = 1'b1;
                        bad_cnt_n = {BAD_W{1'b0}};
                    end else if (win_done_r) begin
                        state_n    = ACQ;
                        lf_clr_n   = 1'b1;
                        sym_cnt_n  = {SYM_W{1'b0}};
                        good_cnt_n = {GOOD_W{1'b0}};
                    end else begin
                        state_n = SETTLE;
                    end
                end
                TRACK: begin
                    if (win_done_r && bad_win_s) begin
                        if ((bad_cnt_r + BAD_W'(1)) == LOCK_BAD_C) begin
                            locked_n  = 1'b0;
                            bad_cnt_n = {BAD_W{1'b0}};
`ifdef LOCK_LOSS_REACQ_EN
                            state_n    = ACQ;
                            lf_clr_n   = 1'b1;
                            sym_cnt_n  = {SYM_W{1'b0}};
                            good_cnt_n = {GOOD_W{1'b0}};
                            win_clr_s  = 1'b1;
`else
                            state_n = TRACK;
`endif
                        end else begin
                            bad_cnt_n = bad_cnt_r + BAD_W'(1);
                        end
                    end else if (win_done_r) begin
                        bad_cnt_n = {BAD_W{1'b0}};
                        locked_n  = good_win_s ? 1'b1 : locked_r;
                    end else begin
                        bad_cnt_n = bad_cnt_r;
                    end
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
        lf_hold_n = (state_n == IDLE) || ((state_n == SETTLE) && (state_r != SETTLE));
        // Gains follow the registered state, so they move one cycle after a transition.
        if (start_i) begin
            kp_n = KP_ACQ_C;
            ki_n = KI_ACQ_C;
        end else if ((state_r == SETTLE) || (state_r == TRACK)) begin
            kp_n = KP_TRK_C;
            ki_n = KI_TRK_C;
        end else begin
            kp_n = KP_ACQ_C;
            ki_n = KI_ACQ_C;
        end
    end

    // Control state and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= IDLE;
            sym_cnt_r  <= {SYM_W{1'b0}};
            good_cnt_r <= {GOOD_W{1'b0}};
            bad_cnt_r  <= {BAD_W{1'b0}};
            locked_r   <= 1'b0;
            lf_clr_r   <= 1'b0;
            lf_hold_r  <= 1'b1;
            kp_r       <= KP_ACQ_C;
            ki_r       <= KI_ACQ_C;
        end else begin
            state_r    <= state_n;
            sym_cnt_r  <= sym_cnt_n;
            good_cnt_r <= good_cnt_n;
            bad_cnt_r  <= bad_cnt_n;
            locked_r   <= locked_n;
            lf_clr_r   <= lf_clr_n;
            lf_hold_r  <= lf_hold_n;
            kp_r       <= kp_n;
            ki_r       <= ki_n;
        end
    end

    assign kp_shift_o = kp_r;
    assign ki_shift_o = ki_r;
    assign lf_clr_o   = lf_clr_r;
    assign lf_hold_o  = lf_hold_r;
    assign state_o    = state_r;
    assign locked_o   = locked_r;
    assign win_avg_o  = win_avg_r;
endmodule

// File: tb/tb_timing_loop_gear_ctrl.sv
// Directed self-checking bench for timing_loop_gear_ctrl; lock-loss expectations
// follow LOCK_LOSS_REACQ_EN.
module tb_timing_loop_gear_ctrl;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start_i = 1'b0;
    logic [17:0] e_in_i = 18'd0;
    logic        e_valid_i = 1'b0;
    logic [4:0]  kp_shift_o, ki_shift_o;
    logic        lf_clr_o, lf_hold_o, locked_o;
    logic [1:0]  state_o;
    logic [17:0] win_avg_o;
    int n_cmp = 0;
    int n_err = 0;

    timing_loop_gear_ctrl dut (
        .clk(clk), .reset_n(reset_n), .start_i(start_i), .e_in_i(e_in_i),
        .e_valid_i(e_valid_i), .kp_shift_o(kp_shift_o), .ki_shift_o(ki_shift_o),
        .lf_clr_o(lf_clr_o), .lf_hold_o(lf_hold_o), .state_o(state_o),
        .locked_o(locked_o), .win_avg_o(win_avg_o)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // n strobes two cycles apart; returns one cycle after the last strobe edge.
    task automatic send_syms(input int n, input int mag, input bit alt);
        for (int i = 0; i < n; i++) begin
            e_in_i    = (alt && i[0]) ? 18'(-mag) : 18'(mag);
            e_valid_i = 1'b1;
            tick();
            e_valid_i = 1'b0;
            tick();
        end
    endtask

    task automatic do_start();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    initial begin
        repeat (3) tick();
        reset_n = 1'b1;
        repeat (10) tick();
        check_val("rst_state", state_o, 0);
        check_val("rst_hold", lf_hold_o, 1);
        check_val("rst_kp", kp_shift_o, 5);
        check_val("rst_ki", ki_shift_o, 9);
        check_val("rst_locked", locked_o, 0);
        check_val("rst_clr", lf_clr_o, 0);
        check_val("rst_avg", win_avg_o, 0);

        do_start();
        check_val("start_clr", lf_clr_o, 1);
        check_val("start_state", state_o, 1);
        check_val("start_hold", lf_hold_o, 0);
        tick();
        check_val("start_clr_end", lf_clr_o, 0);
        send_syms(255, 100, 1'b1);
        send_syms(1, 100, 1'b0);
        check_val("acq_256_state", state_o, 1);
        check_val("acq_avg", win_avg_o, 100);
        send_syms(64, 100, 1'b1);
        check_val("settle_state", state_o, 2);
        check_val("settle_kp_old", kp_shift_o, 5);
        check_val("settle_hold", lf_hold_o, 1);
        check_val("settle_noclr", lf_clr_o, 0);
        tick();
        check_val("settle_kp", kp_shift_o, 7);
        check_val("settle_ki", ki_shift_o, 12);
        check_val("settle_hold_end", lf_hold_o, 0);
        send_syms(64, 100, 1'b1);
        check_val("track_state", state_o, 3);
        check_val("track_locked", locked_o, 1);

        send_syms(64, 1100, 1'b1);
        check_val("bad1_state", state_o, 3);
        check_val("bad1_locked", locked_o, 1);
        check_val("bad1_avg", win_avg_o, 1100);
        send_syms(64, 1100, 1'b1);
        check_val("loss_locked", locked_o, 0);
`ifdef LOCK_LOSS_REACQ_EN
        check_val("loss_state", state_o, 1);
        check_val("loss_clr", lf_clr_o, 1);
        tick();
        check_val("loss_kp", kp_shift_o, 5);
        check_val("loss_ki", ki_shift_o, 9);
`else
        check_val("loss_state", state_o, 3);
        check_val("loss_clr", lf_clr_o, 0);
        tick();
        check_val("loss_kp", kp_shift_o, 7);
        send_syms(64, 100, 1'b0);
        check_val("relock", locked_o, 1);
        check_val("relock_state", state_o, 3);
`endif

        do_start();
        check_val("restart_locked", locked_o, 0);
        send_syms(320, 100, 1'b0);
        check_val("fail_settle", state_o, 2);
        send_syms(64, 600, 1'b1);
        check_val("fail_state", state_o, 1);
        check_val("fail_clr", lf_clr_o, 1);
        check_val("fail_avg", win_avg_o, 600);
        tick();
        check_val("fail_kp", kp_shift_o, 5);
        check_val("fail_ki", ki_shift_o, 9);

        do_start();
        send_syms(320, 1000, 1'b1);
        check_val("alt_state", state_o, 1);
        check_val("alt_avg", win_avg_o, 1000);

        send_syms(64, -131072, 1'b0);
        check_val("sat_avg", win_avg_o, 131071);
        check_val("sat_state", state_o, 1);

        do_start();
        send_syms(384, 100, 1'b0);
        check_val("pre_coinc_state", state_o, 3);
        e_in_i    = 18'd64000;
        e_valid_i = 1'b1;
        start_i   = 1'b1;
        tick();
        start_i   = 1'b0;
        e_valid_i = 1'b0;
        check_val("coinc_state", state_o, 1);
        check_val("coinc_clr", lf_clr_o, 1);
        check_val("coinc_locked", locked_o, 0);
        tick();
        send_syms(63, 200, 1'b0);
        check_val("coinc_avg_63", win_avg_o, 100);
        send_syms(1, 200, 1'b0);
        check_val("coinc_avg_64", win_avg_o, 200);

        send_syms(30, 5000, 1'b0);
        #2;
        reset_n = 1'b0;
        #2;
        check_val("arst_state", state_o, 0);
        check_val("arst_avg", win_avg_o, 0);
        check_val("arst_hold", lf_hold_o, 1);
        reset_n = 1'b1;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
